// File: rtl/imu_spi_responder_pkg.sv
// imu_spi_responder_pkg: shared types, register addresses and FSM states for the IMU SPI responder
package imu_spi_responder_pkg;
  typedef logic [95:0] data_t;
  localparam logic [6:0] WHO_AM_I = 7'h0F;
  localparam logic [6:0] CTRL1_XL = 7'h10;
  localparam logic [6:0] CTRL2_G = 7'h11;
  localparam logic [6:0] OUTX_L_G = 7'h22;
  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;
endpackage

// File: rtl/imu_spi_responder_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sr <= STAGES'({sr, d});
      prev <= sr[STAGES-1];
    end
  end
  assign q = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/imu_spi_responder.sv
// imu_spi_responder: SPI mode-3 slave serving the IMU register map in place of the physical sensor
module imu_spi_responder
  import imu_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6C,
  parameter logic [6:0] DATA_BASE = OUTX_L_G,
  parameter logic [6:0] CTRL_LO = CTRL1_XL,
  parameter logic [6:0] CTRL_HI = 7'h1F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS,
  input  logic        SPC,
  input  logic        SDI,
  output logic        SDO,
  input  data_t       sensor_data,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  ctrl_xl,
  output logic [7:0]  ctrl_g,
  output logic        busy
);
  localparam int NCTRL = int'(CTRL_HI) - int'(CTRL_LO) + 1;
  localparam int IW = NCTRL > 1 ? $clog2(NCTRL) : 1;
  localparam logic [IW-1:0] XL_IDX = IW'(CTRL1_XL - CTRL_LO);
  localparam logic [IW-1:0] G_IDX = IW'(CTRL2_G - CTRL_LO);
  state_t state, nxt;
  logic cs_s, cs_fall, cs_rise_unused;
  logic spc_rise, spc_fall, spc_s_unused;
  logic sdi_s, sdi_rise_unused, sdi_fall_unused;
  logic [2:0] cnt;
  logic [7:0] sr, tx, shifted;
  logic [6:0] addr, addr_inc;
  logic last;
  data_t shadow;
  logic [7:0] regs [NCTRL];
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(CS), .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_spc (
    .clk(clk), .rst_n(rst_n), .d(SPC), .q(spc_s_unused), .rise(spc_rise), .fall(spc_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (
    .clk(clk), .rst_n(rst_n), .d(SDI), .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );
  function automatic logic in_ctrl(input logic [6:0] a);
    return a >= CTRL_LO && a <= CTRL_HI;
  endfunction
  function automatic logic [7:0] rmap(input logic [6:0] a);
    logic [6:0] k;
    k = a - DATA_BASE;
    if (a == WHO_AM_I) return WHO_AM_I_VAL;
    if (in_ctrl(a)) return regs[IW'(a - CTRL_LO)];
    if (k < 7'd12) return shadow[{k[3:0], 3'b000} +: 8];
    return 8'h00;
  endfunction
  always_comb begin
    shifted = {sr[6:0], sdi_s};
    last = cnt == 3'd7;
    addr_inc = addr + 7'd1;
    nxt = cs_fall ? CMD : cs_s ? IDLE : (state == CMD && spc_rise && last) ? (shifted[7] ? RD : WR) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      addr <= '0;
      shadow <= '0;
      SDO <= 1'b1;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < NCTRL; i++) regs[i] <= '0;
    end else begin
      state <= nxt;
      wr_en <= 1'b0;
      if (cs_fall) begin
        shadow <= sensor_data;
        cnt <= '0;
        SDO <= 1'b1;
      end else if (cs_s) begin
        SDO <= 1'b1;
      end else if (spc_fall && state == RD) begin
        SDO <= tx[7];
        tx <= {tx[6:0], 1'b0};
      end else if (spc_rise && state != IDLE) begin
        cnt <= cnt + 3'd1;
        sr <= shifted;
        if (last && state == CMD) begin
          addr <= shifted[6:0];
          tx <= rmap(shifted[6:0]);
        end
        if (last && state == RD) begin
          addr <= addr_inc;
          tx <= rmap(addr_inc);
        end
        if (last && state == WR) begin
          addr <= addr_inc;
          if (in_ctrl(addr)) begin
            regs[IW'(addr - CTRL_LO)] <= shifted;
            wr_en <= 1'b1;
            wr_addr <= addr;
            wr_data <= shifted;
          end
        end
      end
    end
  end
  assign busy = ~cs_s;
  assign ctrl_xl = regs[XL_IDX];
  assign ctrl_g = regs[G_IDX];
endmodule

// File: tb/tb_imu_spi_responder.sv
// tb_imu_spi_responder: randomized SPI master checked against a register-map reference model
module tb_imu_spi_responder;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic CS = 1'b1;
  logic SPC = 1'b1;
  logic SDI = 1'b1;
  logic [95:0] sensor_data = '0;
  logic SDO, wr_en, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data, ctrl_xl, ctrl_g;
  int n_tests = 0;
  int n_fail = 0;
  int gi = 0;
  logic [7:0] m_ctrl [16];
  logic [6:0] m_waddr = '0;
  logic [7:0] m_wdata = '0;
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];
  logic [7:0] b;
  logic [6:0] a;
  imu_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .SPC(SPC), .SDI(SDI), .SDO(SDO),
    .sensor_data(sensor_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ctrl_xl(ctrl_xl), .ctrl_g(ctrl_g), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && wr_en) got_q.push_back({wr_addr, wr_data});
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] model_rd(input logic [6:0] ad, input logic [95:0] snap);
    if (ad == 7'h0F) return 8'h6C;
    if (ad >= 7'h10 && ad <= 7'h1F) return m_ctrl[ad[3:0]];
    if (ad >= 7'h22 && ad <= 7'h2D) return snap[8*(int'(ad) - 34) +: 8];
    return 8'h00;
  endfunction
  task automatic spi_bits(input logic [7:0] mosi, input int nb, output logic [7:0] miso);
    miso = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      repeat (H) @(negedge clk);
      SPC = 1'b0;
      SDI = mosi[i];
      repeat (H) @(negedge clk);
      miso[i] = SDO;
      SPC = 1'b1;
    end
  endtask
  task automatic spi_begin();
    CS = 1'b0;
    repeat (H) @(negedge clk);
  endtask
  task automatic spi_end();
    repeat (H) @(negedge clk);
    CS = 1'b1;
    SDI = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask
  task automatic chk_writes();
    chk("wr_count", 96'(got_q.size() - gi), 96'(exp_q.size()));
    foreach (exp_q[i]) if (gi + i < got_q.size()) chk("wr_event", 96'(got_q[gi + i]), 96'(exp_q[i]));
    gi = got_q.size();
    exp_q.delete();
    chk("wr_addr", 96'(wr_addr), 96'(m_waddr));
    chk("wr_data", 96'(wr_data), 96'(m_wdata));
    chk("ctrl_xl", 96'(ctrl_xl), 96'(m_ctrl[0]));
    chk("ctrl_g", 96'(ctrl_g), 96'(m_ctrl[1]));
    chk("sdo_idle", 96'(SDO), 96'(1));
    chk("busy_idle", 96'(busy), 96'(0));
  endtask
  task automatic do_read(input logic [6:0] ad, input int n, input int chg_at);
    logic [95:0] snap;
    logic [7:0] rb;
    logic [6:0] cur;
    spi_begin();
    snap = sensor_data;
    chk("busy", 96'(busy), 96'(1));
    spi_bits({1'b1, ad}, 8, rb);
    for (int k = 0; k < n; k++) begin
      cur = ad + 7'(k);
      spi_bits(8'h00, 8, rb);
      chk($sformatf("rd_%02h", cur), 96'(rb), 96'(model_rd(cur, snap)));
      if (k == chg_at) sensor_data = '1;
    end
    spi_end();
    chk_writes();
  endtask
  task automatic do_write(input logic [6:0] ad, input int n, input logic [7:0] d0);
    logic [7:0] rb, d;
    logic [6:0] cur;
    spi_begin();
    spi_bits({1'b0, ad}, 8, rb);
    for (int k = 0; k < n; k++) begin
      cur = ad + 7'(k);
      d = k == 0 ? d0 : 8'($urandom);
      spi_bits(d, 8, rb);
      if (cur >= 7'h10 && cur <= 7'h1F) begin
        m_ctrl[cur[3:0]] = d;
        m_waddr = cur;
        m_wdata = d;
        exp_q.push_back({cur, d});
      end
    end
    spi_end();
    chk_writes();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) m_ctrl[i] = '0;
    repeat (4) @(negedge clk);
    chk("rst_sdo", 96'(SDO), 96'(1));
    chk("rst_wr_en", 96'(wr_en), 96'(0));
    chk("rst_wr_addr", 96'(wr_addr), 96'(0));
    chk("rst_wr_data", 96'(wr_data), 96'(0));
    chk("rst_ctrl_xl", 96'(ctrl_xl), 96'(0));
    chk("rst_ctrl_g", 96'(ctrl_g), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(7'h0F, 1, -1);
    do_write(7'h10, 1, 8'h60);
    do_read(7'h10, 1, -1);
    sensor_data = 96'h0C0B0A09_08070605_04030201;
    do_read(7'h22, 13, 1);
    do_write(7'h0F, 1, 8'hAA);
    do_read(7'h0F, 1, -1);
    do_read(7'h7F, 2, -1);
    do_write(7'h1F, 2, 8'h5A);
    spi_begin();
    spi_bits(8'h11, 8, b);
    spi_bits(8'hFF, 5, b);
    spi_end();
    chk_writes();
    do_write(7'h11, 1, 8'h3C);
    spi_begin();
    spi_bits(8'h8F, 8, b);
    spi_bits(8'h00, 1, b);
    chk("rd_first_bit", 96'(b[7]), 96'(0));
    rst_n = 1'b0;
    #1;
    chk("rstmid_sdo", 96'(SDO), 96'(1));
    chk("rstmid_busy", 96'(busy), 96'(0));
    chk("rstmid_ctrl_xl", 96'(ctrl_xl), 96'(0));
    for (int i = 0; i < 16; i++) m_ctrl[i] = '0;
    m_waddr = '0;
    m_wdata = '0;
    exp_q.delete();
    gi = got_q.size();
    repeat (3) @(negedge clk);
    CS = 1'b1;
    SDI = 1'b1;
    rst_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    chk_writes();
    do_read(7'h0F, 1, -1);
    for (int t = 0; t < 16; t++) begin
      sensor_data = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: a = 7'($urandom);
        1: a = 7'h0E + 7'($urandom_range(0, 3));
        2: a = 7'h1D + 7'($urandom_range(0, 5));
        default: a = 7'h20 + 7'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 1) == 1) do_read(a, int'($urandom_range(1, 3)), -1);
      else do_write(a, int'($urandom_range(1, 3)), 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
